// File: rtl/thermo_sample_logger_pkg.sv
// Shared types and entry layout for the thermocouple sample logger.
// Entry = {seq[9:0], timeout, fault, temp[11:0]}.
package thermo_logger_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  localparam int ENTRY_W = 24;
  localparam int SEQ_W   = 10;
  localparam int SEQ_LSB = 14;
  localparam int TMO_BIT = 13;
  localparam int FLT_BIT = 12;
  localparam int TEMP_W  = 12;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [SEQ_W-1:0]  seq,
    input logic              tmo,
    input logic              flt,
    input logic [TEMP_W-1:0] temp
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[SEQ_LSB +: SEQ_W] = seq;
    e[TMO_BIT] = tmo;
    e[FLT_BIT] = flt;
    e[0 +: TEMP_W] = temp;
    return e;
  endfunction

endpackage

// File: rtl/thermo_sample_logger_if.sv
// Reader-side valid/ready port of the sample logger FIFO.
// master = logger, slave = reader.
interface thermo_sample_logger_if;
  import thermo_logger_pkg::*;

  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/thermo_sample_logger_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit.
// A push into a full FIFO is taken only when a pop frees a slot that cycle.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  output logic                     full,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/thermo_sample_logger.sv
// Periodic thermocouple SPI reader: start, wait, capture, tag and buffer.
// Samples are tagged with a free-running sequence number so drops show as gaps.
module thermo_sample_logger
  import thermo_logger_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 4096,
  parameter int TEMP_LSB  = 2,
  parameter int FAULT_BIT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [23:0]              period_cycles,
  output logic                     spi_start,
  input  logic                     spi_busy,
  input  logic [15:0]              spi_dout,
  thermo_sample_logger_if.master   rd,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               overflow_cnt,
  output logic [TEMP_W-1:0]        last_temp
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

  state_t              state;
  logic [23:0]         tick_cnt;
  logic [23:0]         per_m1;
  logic                tick;
  logic [WW-1:0]       wait_cnt;
  logic                tmo;
  logic [15:0]         spi_word;
  logic [SEQ_W-1:0]    seq;
  logic [TEMP_W-1:0]   temp_f;
  logic                flt_f;
  logic [ENTRY_W-1:0]  entry;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;

  assign per_m1 = (period_cycles == '0) ? '0 : period_cycles - 24'd1;
  assign tick   = enable && (tick_cnt >= per_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 24'd1;
    end
  end

  // Start is qualified by IDLE so ticks during a transaction are lost.
  assign spi_start = (state == S_IDLE) && tick;

  assign temp_f = spi_word[TEMP_LSB +: TEMP_W];
  assign flt_f  = spi_word[FAULT_BIT];
  assign entry  = tmo ? pack_entry(seq, 1'b1, 1'b1, '0)
                      : pack_entry(seq, 1'b0, flt_f, temp_f);

  assign push = (state == S_CAPTURE);
  assign pop  = rd.rd_valid & rd.rd_ready;
  assign drop = push & full & ~pop;
  assign rd.rd_valid = ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      tmo          <= 1'b0;
      spi_word     <= '0;
      seq          <= '0;
      last_temp    <= '0;
      overflow_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (tick) begin
            wait_cnt <= '0;
            tmo      <= 1'b0;
            state    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (spi_busy) begin
            wait_cnt <= '0;
            state    <= S_WAIT_DONE;
          end else if (wait_cnt == WAIT_MAX) begin
            tmo   <= 1'b1;
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
            spi_word <= spi_dout;
            state    <= S_CAPTURE;
          end else if (wait_cnt == WAIT_MAX) begin
            tmo   <= 1'b1;
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          seq <= seq + 1'b1;
          if (!tmo) last_temp <= temp_f;
          if (drop && overflow_cnt != 8'hFF) begin
            overflow_cnt <= overflow_cnt + 8'd1;
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (entry),
    .full  (full),
    .pop   (pop),
    .dout  (rd.rd_data),
    .empty (empty),
    .count (fifo_count)
  );

endmodule
